// File: rtl/sw_seq_feeder_if.sv
// Bundles the character input, core stream and result handshake of sw_seq_feeder.
interface sw_seq_feeder_if;
  // Upstream character port
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_char;
  // Systolic core side
  logic        sw_valid;
  logic [1:0]  sw_data_s;
  logic [1:0]  sw_data_t;
  logic        sw_finish;
  logic [11:0] sw_max;
  // Result port
  logic        res_valid;
  logic        res_ready;
  logic [11:0] res_max;
  logic        res_err;
  logic        res_timeout;
  logic        busy;

  // Feeder side
  modport master (
    input  in_valid, in_char, sw_finish, sw_max, res_ready,
    output in_ready, sw_valid, sw_data_s, sw_data_t,
           res_valid, res_max, res_err, res_timeout, busy
  );

  // Environment side (upstream source, core and result consumer)
  modport slave (
    output in_valid, in_char, sw_finish, sw_max, res_ready,
    input  in_ready, sw_valid, sw_data_s, sw_data_t,
           res_valid, res_max, res_err, res_timeout, busy
  );
endinterface

// File: rtl/sw_seq_feeder.sv
// Front-end of the Smith-Waterman core: loads S then T as 2-bit symbols,
// streams both as one gap-free burst, then returns the core score.
module sw_seq_feeder #(
  parameter int unsigned SEQ_LEN = 256,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic            clk,
  input  logic            reset,
  sw_seq_feeder_if.master io
);

  localparam int unsigned AW = $clog2(2 * SEQ_LEN);
  localparam int unsigned IW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [AW-1:0] LAST_CHAR = AW'(2 * SEQ_LEN - 1);
  localparam logic [AW-1:0] LAST_SYM  = AW'(SEQ_LEN - 1);
  localparam logic [AW-1:0] T_BASE    = AW'(SEQ_LEN);
  localparam logic [TW-1:0] T_LIMIT   = TW'(TIMEOUT);

  typedef enum logic [1:0] {ST_LOAD, ST_STREAM, ST_WAIT, ST_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic [TW-1:0] r_tcnt, w_tcnt_nxt;
  logic          r_err, w_err_nxt;

  logic          r_in_ready, w_in_ready_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_sw_valid, w_sw_valid_nxt;
  logic [1:0]    r_sw_data_s, w_sw_data_s_nxt;
  logic [1:0]    r_sw_data_t, w_sw_data_t_nxt;
  logic          r_res_valid, w_res_valid_nxt;
  logic [11:0]   r_res_max, w_res_max_nxt;
  logic          r_res_err, w_res_err_nxt;
  logic          r_res_timeout, w_res_timeout_nxt;

  logic [1:0]    r_s_buf [SEQ_LEN];
  logic [1:0]    r_t_buf [SEQ_LEN];

  logic [1:0]    w_enc;
  logic          w_bad;
  logic          w_accept;
  logic          w_in_s;
  logic          w_wr_s;
  logic          w_wr_t;
  logic [IW-1:0] w_wr_idx;
  logic [IW-1:0] w_rd_idx;
  logic [1:0]    w_rd_s;
  logic [1:0]    w_rd_t;

  // Case-insensitive nucleotide encoder; anything else maps to 00 and flags an error
  always_comb begin
    w_enc = 2'b00;
    w_bad = 1'b0;
    case (io.in_char)
      8'h41, 8'h61: w_enc = 2'b00;
      8'h43, 8'h63: w_enc = 2'b01;
      8'h47, 8'h67: w_enc = 2'b10;
      8'h54, 8'h74: w_enc = 2'b11;
      default:      w_bad = 1'b1;
    endcase
  end

  assign w_accept = (r_state == ST_LOAD) && io.in_valid && r_in_ready;
  assign w_in_s   = (r_addr < T_BASE);
  assign w_wr_s   = w_accept && w_in_s;
  assign w_wr_t   = w_accept && !w_in_s;
  assign w_wr_idx = w_in_s ? IW'(r_addr) : IW'(r_addr - T_BASE);

  // Element 0 is fetched on the final load edge; later elements use addr+1
  assign w_rd_idx = (r_state == ST_LOAD) ? '0 : IW'(r_addr + AW'(1));
  assign w_rd_s   = r_s_buf[w_rd_idx];
  // With a single-symbol T, its only slot is written on the same edge it is read
  assign w_rd_t   = ((SEQ_LEN == 1) && (r_state == ST_LOAD)) ? w_enc : r_t_buf[w_rd_idx];

  // Symbol buffers; stale contents are harmless because the address restarts at 0
  always_ff @(posedge clk) begin
    if (w_wr_s) r_s_buf[w_wr_idx] <= w_enc;
    if (w_wr_t) r_t_buf[w_wr_idx] <= w_enc;
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_addr_nxt        = r_addr;
    w_tcnt_nxt        = r_tcnt;
    w_err_nxt         = r_err;
    w_sw_valid_nxt    = 1'b0;
    w_sw_data_s_nxt   = 2'b00;
    w_sw_data_t_nxt   = 2'b00;
    w_res_valid_nxt   = r_res_valid;
    w_res_max_nxt     = r_res_max;
    w_res_err_nxt     = r_res_err;
    w_res_timeout_nxt = r_res_timeout;

    case (r_state)
      ST_LOAD: begin
        if (w_accept) begin
          if (w_bad) w_err_nxt = 1'b1;
          if (r_addr == LAST_CHAR) begin
            w_state_nxt     = ST_STREAM;
            w_addr_nxt      = '0;
            w_sw_valid_nxt  = 1'b1;
            w_sw_data_s_nxt = w_rd_s;
            w_sw_data_t_nxt = w_rd_t;
          end else begin
            w_addr_nxt = r_addr + AW'(1);
          end
        end
      end
      ST_STREAM: begin
        if (r_addr == LAST_SYM) begin
          w_state_nxt = ST_WAIT;
          w_addr_nxt  = '0;
          w_tcnt_nxt  = '0;
        end else begin
          w_addr_nxt      = r_addr + AW'(1);
          w_sw_valid_nxt  = 1'b1;
          w_sw_data_s_nxt = w_rd_s;
          w_sw_data_t_nxt = w_rd_t;
        end
      end
      ST_WAIT: begin
        if (io.sw_finish) begin
          w_state_nxt       = ST_DONE;
          w_res_valid_nxt   = 1'b1;
          w_res_max_nxt     = io.sw_max;
          w_res_err_nxt     = r_err;
          w_res_timeout_nxt = 1'b0;
        end else if (r_tcnt == T_LIMIT) begin
          w_state_nxt       = ST_DONE;
          w_res_valid_nxt   = 1'b1;
          w_res_max_nxt     = 12'd0;
          w_res_err_nxt     = r_err;
          w_res_timeout_nxt = 1'b1;
        end else begin
          w_tcnt_nxt = r_tcnt + TW'(1);
        end
      end
      ST_DONE: begin
        if (io.res_ready) begin
          w_state_nxt     = ST_LOAD;
          w_res_valid_nxt = 1'b0;
          w_addr_nxt      = '0;
          w_tcnt_nxt      = '0;
          w_err_nxt       = 1'b0;
        end
      end
      default: w_state_nxt = ST_LOAD;
    endcase

    w_in_ready_nxt = (w_state_nxt == ST_LOAD);
    w_busy_nxt     = (w_state_nxt != ST_LOAD);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_LOAD;
      r_addr        <= '0;
      r_tcnt        <= '0;
      r_err         <= 1'b0;
      r_in_ready    <= 1'b1;
      r_busy        <= 1'b0;
      r_sw_valid    <= 1'b0;
      r_sw_data_s   <= 2'b00;
      r_sw_data_t   <= 2'b00;
      r_res_valid   <= 1'b0;
      r_res_max     <= 12'd0;
      r_res_err     <= 1'b0;
      r_res_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_addr        <= w_addr_nxt;
      r_tcnt        <= w_tcnt_nxt;
      r_err         <= w_err_nxt;
      r_in_ready    <= w_in_ready_nxt;
      r_busy        <= w_busy_nxt;
      r_sw_valid    <= w_sw_valid_nxt;
      r_sw_data_s   <= w_sw_data_s_nxt;
      r_sw_data_t   <= w_sw_data_t_nxt;
      r_res_valid   <= w_res_valid_nxt;
      r_res_max     <= w_res_max_nxt;
      r_res_err     <= w_res_err_nxt;
      r_res_timeout <= w_res_timeout_nxt;
    end
  end

  assign io.in_ready    = r_in_ready;
  assign io.busy        = r_busy;
  assign io.sw_valid    = r_sw_valid;
  assign io.sw_data_s   = r_sw_data_s;
  assign io.sw_data_t   = r_sw_data_t;
  assign io.res_valid   = r_res_valid;
  assign io.res_max     = r_res_max;
  assign io.res_err     = r_res_err;
  assign io.res_timeout = r_res_timeout;

endmodule
